// File: rtl/uart_hex_reporter_pkg.sv
// Shared types and ASCII constants for the hex-over-UART reporter.
package uart_hex_reporter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PFX,
    ST_HI,
    ST_LO,
    ST_CR,
    ST_LF
  } state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;

endpackage

// File: rtl/uart_hex_reporter_nibble_to_ascii.sv
// Combinational 4-bit to uppercase hex ASCII character.
module nibble_to_ascii
  import uart_hex_reporter_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) ascii = ASCII_0 + {4'h0, nibble};
    else                ascii = ASCII_A + {4'h0, nibble} - 8'd10;
  end

endmodule

// File: rtl/uart_hex_reporter.sv
// Sends one byte as two hex characters, with optional prefix and CR/LF, to a uart_tx.
//
// state   | meaning
// IDLE    | waiting for start
// PFX     | presenting PREFIX character
// HI      | presenting high-nibble character
// LO      | presenting low-nibble character
// CR      | presenting carriage return
// LF      | presenting line feed
module uart_hex_reporter
  import uart_hex_reporter_pkg::*;
#(
  parameter logic [7:0] PREFIX   = 8'h00,
  parameter bit         EOL_CRLF = 1'b1
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] value,
  output logic       busy,
  output logic       done,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready
);

  state_t     state;
  state_t     nxt_state;
  logic [7:0] val_q;
  logic [7:0] nib_src;
  logic [7:0] hi_char;
  logic [7:0] lo_char;
  logic [7:0] nxt_byte;

  // In IDLE the first digit must come from the live input, since it is captured on the same edge.
  assign nib_src = (state == ST_IDLE) ? value : val_q;

  nibble_to_ascii u_hi (.nibble(nib_src[7:4]), .ascii(hi_char));
  nibble_to_ascii u_lo (.nibble(nib_src[3:0]), .ascii(lo_char));

  always_comb begin
    nxt_state = ST_IDLE;
    case (state)
      ST_IDLE: begin
        if (PREFIX != 8'h00) nxt_state = ST_PFX;
        else                 nxt_state = ST_HI;
      end
      ST_PFX:  nxt_state = ST_HI;
      ST_HI:   nxt_state = ST_LO;
      ST_LO: begin
        if (EOL_CRLF) nxt_state = ST_CR;
        else          nxt_state = ST_IDLE;
      end
      ST_CR:   nxt_state = ST_LF;
      ST_LF:   nxt_state = ST_IDLE;
      default: nxt_state = ST_IDLE;
    endcase
  end

  always_comb begin
    nxt_byte = 8'h00;
    case (nxt_state)
      ST_PFX:  nxt_byte = PREFIX;
      ST_HI:   nxt_byte = hi_char;
      ST_LO:   nxt_byte = lo_char;
      ST_CR:   nxt_byte = ASCII_CR;
      ST_LF:   nxt_byte = ASCII_LF;
      default: nxt_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      val_q    <= 8'h00;
      busy     <= 1'b0;
      done     <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE) begin
        if (start) begin
          val_q    <= value;
          state    <= nxt_state;
          busy     <= 1'b1;
          tx_valid <= 1'b1;
          tx_data  <= nxt_byte;
        end
      end else if (tx_valid && tx_ready) begin
        if (nxt_state == ST_IDLE) begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          done     <= 1'b1;
          tx_valid <= 1'b0;
          tx_data  <= 8'h00;
        end else begin
          state   <= nxt_state;
          tx_data <= nxt_byte;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_hex_reporter.sv
// Bench for uart_hex_reporter: default build and a PREFIX='$', no-EOL build side by side.
module tb_uart_hex_reporter;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    logic [7:0] value;
    int         dut;
    int         mode;   // 0: ready high, 1: random ready, 2: ready low for 10 cycles
    bit         noise;  // pulse start / change value while busy
    int         n;
    logic [7:0] b0, b1, b2, b3;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a[2];
  logic [7:0] value_a[2];
  logic       tx_ready_a[2];
  logic       busy_a[2];
  logic       done_a[2];
  logic       tx_valid_a[2];
  logic [7:0] tx_data_a[2];

  int errors = 0;
  int checks = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  uart_hex_reporter dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_a[0]), .value(value_a[0]),
    .busy(busy_a[0]), .done(done_a[0]), .tx_valid(tx_valid_a[0]),
    .tx_data(tx_data_a[0]), .tx_ready(tx_ready_a[0])
  );

  uart_hex_reporter #(.PREFIX(8'h24), .EOL_CRLF(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_a[1]), .value(value_a[1]),
    .busy(busy_a[1]), .done(done_a[1]), .tx_valid(tx_valid_a[1]),
    .tx_data(tx_data_a[1]), .tx_ready(tx_ready_a[1])
  );

  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [7:0] hex_char(input int n);
    if (n < 10) return 8'(48 + n);
    return 8'(65 + n - 10);
  endfunction

  // Reference frame from the configuration of each instance.
  function automatic bq_t model_frame(input int d, input logic [7:0] v);
    bq_t q;
    if (d == 1) q.push_back(8'h24);
    q.push_back(hex_char(int'(v) / 16));
    q.push_back(hex_char(int'(v) % 16));
    if (d == 0) begin
      q.push_back(8'h0D);
      q.push_back(8'h0A);
    end
    return q;
  endfunction

  task automatic add_vec(input logic [7:0] v, input int d, input int mode, input bit noise,
                         input int n, input logic [7:0] b0, b1, b2, b3);
    vec_t e;
    e.value = v; e.dut = d; e.mode = mode; e.noise = noise; e.n = n;
    e.b0 = b0; e.b1 = b1; e.b2 = b2; e.b3 = b3;
    tbl.push_back(e);
  endtask

  // Entered at a negedge with the chosen DUT idle; returns in its done cycle.
  task automatic run_frame(input int d, input logic [7:0] v, input int mode, input bit noise,
                           input bq_t exp, input string nm);
    bq_t        got;
    int         ticks;
    bit         stalled;
    bit         r;
    logic [7:0] held;
    start_a[d]    = 1'b1;
    value_a[d]    = v;
    tx_ready_a[d] = (mode != 2);
    tick();
    start_a[d] = 1'b0;
    chk(busy_a[d] && tx_valid_a[d] && !done_a[0] && !done_a[1], {nm, " accept"},
        {busy_a[d], tx_valid_a[d], done_a[0], done_a[1]}, 4'b1100);
    ticks = 0;
    stalled = 1'b0;
    held = 8'h00;
    while (got.size() < exp.size()) begin
      if (stalled)
        chk(tx_valid_a[d] && tx_data_a[d] == held, {nm, " hold"}, int'(tx_data_a[d]), int'(held));
      chk(busy_a[d] && tx_valid_a[d] && !done_a[d], {nm, " inflight"},
          {busy_a[d], tx_valid_a[d], done_a[d]}, 3'b110);
      value_a[d] = 8'($urandom);
      start_a[d] = noise && ($urandom_range(0, 2) == 0);
      case (mode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: r = (ticks >= 10);
      endcase
      tx_ready_a[d] = r;
      stalled = !r;
      held = tx_data_a[d];
      if (r) got.push_back(tx_data_a[d]);
      tick();
      ticks++;
      if (ticks > 200) begin
        chk(1'b0, {nm, " timeout"}, ticks, 200);
        start_a[d] = 1'b0;
        return;
      end
    end
    start_a[d] = 1'b0;
    chk(done_a[d] && !busy_a[d] && !tx_valid_a[d], {nm, " done"},
        {done_a[d], busy_a[d], tx_valid_a[d]}, 3'b100);
    for (int i = 0; i < exp.size(); i++)
      chk(got[i] == exp[i], $sformatf("%s byte%0d", nm, i), int'(got[i]), int'(exp[i]));
    if (mode != 1)
      chk(ticks == exp.size() + ((mode == 2) ? 10 : 0), {nm, " cycles"}, ticks,
          exp.size() + ((mode == 2) ? 10 : 0));
  endtask

  initial begin
    bq_t q;
    for (int d = 0; d < 2; d++) begin
      start_a[d] = 1'b0; value_a[d] = 8'h00; tx_ready_a[d] = 1'b1;
    end

    add_vec(8'h3A, 0, 0, 1'b0, 4, 8'h33, 8'h41, 8'h0D, 8'h0A);
    add_vec(8'h00, 0, 0, 1'b0, 4, 8'h30, 8'h30, 8'h0D, 8'h0A);
    add_vec(8'hFF, 0, 0, 1'b0, 4, 8'h46, 8'h46, 8'h0D, 8'h0A);
    add_vec(8'h3A, 0, 2, 1'b0, 4, 8'h33, 8'h41, 8'h0D, 8'h0A);
    add_vec(8'h3A, 0, 0, 1'b1, 4, 8'h33, 8'h41, 8'h0D, 8'h0A);
    add_vec(8'hC7, 1, 0, 1'b0, 3, 8'h24, 8'h43, 8'h37, 8'h00);
    add_vec(8'h9E, 1, 1, 1'b1, 3, 8'h24, 8'h39, 8'h45, 8'h00);
    add_vec(8'hA5, 0, 1, 1'b0, 4, 8'h41, 8'h35, 8'h0D, 8'h0A);

    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk(!busy_a[d], $sformatf("rst busy%0d", d), int'(busy_a[d]), 0);
      chk(!done_a[d], $sformatf("rst done%0d", d), int'(done_a[d]), 0);
      chk(!tx_valid_a[d], $sformatf("rst valid%0d", d), int'(tx_valid_a[d]), 0);
      chk(tx_data_a[d] == 8'h00, $sformatf("rst data%0d", d), int'(tx_data_a[d]), 0);
    end
    rst_n = 1'b1;

    // Vectors run back to back: each start lands in the previous frame's done cycle.
    for (int i = 0; i < tbl.size(); i++) begin
      q.delete();
      q.push_back(tbl[i].b0); q.push_back(tbl[i].b1); q.push_back(tbl[i].b2);
      if (tbl[i].n == 4) q.push_back(tbl[i].b3);
      run_frame(tbl[i].dut, tbl[i].value, tbl[i].mode, tbl[i].noise, q, $sformatf("vec%0d", i));
    end
    tick();
    chk(!done_a[0] && !done_a[1], "done width", {done_a[0], done_a[1]}, 0);

    // Reset after the high digit has gone out.
    start_a[0] = 1'b1; value_a[0] = 8'h3A; tx_ready_a[0] = 1'b1;
    tick();
    start_a[0] = 1'b0;
    tick();
    chk(tx_valid_a[0] && tx_data_a[0] == 8'h41, "pre-reset LO", int'(tx_data_a[0]), 8'h41);
    #2 rst_n = 1'b0;
    #1;
    chk(!tx_valid_a[0] && !busy_a[0] && tx_data_a[0] == 8'h00, "async reset",
        {tx_valid_a[0], busy_a[0], tx_data_a[0]}, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk(!done_a[0], "no done on reset", int'(done_a[0]), 0);
    end
    rst_n = 1'b1;
    run_frame(0, 8'h3A, 0, 1'b0, model_frame(0, 8'h3A), "post-reset");
    tick();
    chk(!done_a[0], "post-reset done width", int'(done_a[0]), 0);

    // Randomized frames against the model.
    for (int i = 0; i < 20; i++) begin
      int         d;
      logic [7:0] v;
      d = $urandom_range(0, 1);
      v = 8'($urandom);
      run_frame(d, v, $urandom_range(0, 1), 1'($urandom_range(0, 1)), model_frame(d, v),
                $sformatf("rnd%0d", i));
    end
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_hex_reporter.md
UART_HEX_REPORTER -- requirements
Module: uart_hex_reporter

Interface
REQ-001 Parameter PREFIX, default 8'h00, ASCII character sent before the digits; 8'h00 means no prefix.
REQ-002 Parameter EOL_CRLF, default 1, 1 appends 0x0D 0x0A after the digits; 0 appends nothing.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request to report value; sampled only in IDLE.
REQ-006 value  input  8  byte to report, captured on the accepted start edge.
REQ-007 busy  output  1  high from the edge that accepts start until the last byte transfers.
REQ-008 done  output  1  one-cycle pulse in the cycle after the last byte transfers.
REQ-009 tx_valid  output  1  byte available to the downstream uart_tx.
REQ-010 tx_data  output  8  ASCII byte presented to uart_tx.
REQ-011 tx_ready  input  1  uart_tx can accept a byte this cycle.

Function
REQ-012 Transfer SHALL occur on a rising edge where tx_valid and tx_ready are both high.
REQ-013 Once asserted, tx_valid SHALL stay high and tx_data SHALL stay stable until the transfer.
REQ-014 tx_valid SHALL NOT depend combinationally on tx_ready.
REQ-015 Frame order SHALL be [PREFIX], high-nibble char, low-nibble char, [0x0D, 0x0A].
REQ-016 Nibble encoding: 0-9 -> 0x30+n; 10-15 -> 0x41+(n-10), uppercase only.
REQ-017 FSM states: IDLE, PFX, HI, LO, CR, LF. PFX is skipped when PREFIX==0. CR and LF are skipped when EOL_CRLF==0.
REQ-018 From IDLE, start=1 SHALL capture value and enter the first enabled state; tx_valid rises in the next cycle (latency 1).
REQ-019 After each transfer, the FSM SHALL advance to the next enabled state in the next cycle with tx_valid still high. There are no bubbles between bytes.
REQ-020 After the final transfer, the FSM SHALL return to IDLE, with busy=0, tx_valid=0 and done=1 for exactly one cycle.
REQ-021 start while busy SHALL be ignored: the captured value is unchanged and nothing is queued.
REQ-022 start in the same cycle as done SHALL be accepted, since the FSM is in IDLE.
REQ-023 Changes on value after capture SHALL NOT affect the frame in flight.
REQ-024 With tx_ready held high, the frame SHALL take exactly N+1 cycles from start to done, where N is the number of bytes.

Reset
REQ-025 While rst_n=0, outputs SHALL be: busy=0, done=0, tx_valid=0, tx_data=8'h00. The FSM is in IDLE and the captured value is 8'h00.
REQ-026 Reset mid-frame SHALL drop tx_valid immediately (asynchronously) and abandon the frame; no done pulse is issued.
REQ-027 After rst_n deasserts, the block SHALL accept start on the first rising edge.

Structure
REQ-028 The shared package SHALL hold the state enum and the constants ASCII_CR=8'h0D, ASCII_LF=8'h0A, ASCII_0=8'h30 and ASCII_A=8'h41.
REQ-029 Nibble-to-ASCII conversion SHALL be a combinational sub-module, nibble_to_ascii (4-bit in, 8-bit out), instantiated twice.
REQ-030 The block SHALL connect directly to uart_tx's tx_valid/tx_data/tx_ready and needs no baud knowledge.

Verification
REQ-031 Defaults, value=8'h3A, tx_ready=1 -> bytes 0x33, 0x41, 0x0D, 0x0A on 4 consecutive edges; done 1 cycle after the last transfer.
REQ-032 value=8'h00, then 8'hFF -> "00\r\n" then "FF\r\n"; the second start is issued in the done cycle and is accepted with no gap.
REQ-033 tx_ready low for 10 cycles while tx_valid=1 -> tx_data holds 0x33 and busy stays 1; transfer occurs on the first ready edge.
REQ-034 start pulsed with value=8'h55 during a frame of 8'h3A -> the frame still emits 0x33, 0x41 and exactly one frame is sent.
REQ-035 PREFIX=8'h24, EOL_CRLF=0, value=8'hC7 -> bytes 0x24, 0x43, 0x37; done at cycle 4.
REQ-036 rst_n asserted after the HI byte transfers -> tx_valid=0 at once, no done; a new start then sends a complete frame.
